dcache_mem_stage: RTL
=====================

Name: dcache_mem_stage

Overview:
- Memory-stage data cache. Sits directly downstream of the EX/MEM pipeline register and consumes its alu_out, mem_data, mem_read, mem_write and funct3 outputs.
- Small direct-mapped, write-back, write-allocate cache. Drives the d-cache stall that freezes EX/MEM and earlier stages.
- Refills and evicts whole lines over a req/ready handshake to main memory.
- Returns sign/zero-extended load data toward MEM/WB.

Parameters:
NUM_LINES, 4, number of cache lines; power of two; index width = log2(NUM_LINES)
LINE_BYTES, 16, bytes per line; fixed at 16, so the line is 128 bits and the offset is 4 bits

Ports:
clk  input  1  clock, posedge
reset  input  1  asynchronous, active-high reset
in_addr  input  32  byte address (EX/MEM alu_out)
in_wdata  input  32  store data (EX/MEM mem_data)
in_mem_read  input  1  load request
in_mem_write  input  1  store request; never asserted together with in_mem_read
in_funct3  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
out_load_data  output  32  extended load result; valid when out_hit=1 and in_mem_read=1
out_hit  output  1  access completing this cycle
out_d_cache_stall  output  1  freeze request to EX/MEM and upstream stages
out_misaligned  output  1  halfword address not 2-aligned or word address not 4-aligned
mem_req  output  1  main-memory request
mem_we  output  1  1 = line write-back, 0 = line fill
mem_addr  output  32  line-aligned address; low 4 bits always 0
mem_wdata  output  128  evicted line
mem_rdata  input  128  fill line
mem_ready  input  1  one-cycle completion pulse for the current request

Behaviour:
- Address split: offset [3:0], index [3+log2(NUM_LINES):4], tag = remaining upper bits.
- Per-line state: valid bit, dirty bit, tag, 128-bit data.
- FSM states: IDLE, WRITEBACK, FILL.
- Reset (asynchronous, any state):
  - state goes to IDLE; all valid and dirty bits clear; mem_req low.
  - Data and tag storage are not reset.
  - An in-flight memory transaction is abandoned; any late mem_ready is ignored in IDLE.
- Access = (in_mem_read | in_mem_write) & !out_misaligned.
- Hit = valid[idx] & tag match.
- IDLE:
  - Access & hit: out_hit=1, stall=0.
    - Load: data is combinational in the same cycle.
    - Store: merges bytes at posedge (SB 1 byte, SH 2 bytes, SW 4 bytes, little-endian) and sets dirty.
  - Access & miss: stall=1 combinationally. Next state is WRITEBACK if the victim is valid & dirty, else FILL.
  - No access or misaligned: stall=0, out_hit=0. A misaligned access does not modify the cache.
- WRITEBACK:
  - Drive mem_req=1, mem_we=1, mem_addr={victim tag, idx, 4'b0}, mem_wdata=victim line.
  - Hold all of these stable until mem_ready, then go to FILL.
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr={in_addr[31:4], 4'b0}.
  - On mem_ready: write mem_rdata into the line, set valid=1, dirty=0, tag=new tag; go to IDLE.
- The stalled access replays in IDLE the cycle after the fill, now as a hit. Miss penalty therefore = memory cycles + 1 (replay cycle).
- out_d_cache_stall = (state != IDLE) | (IDLE & access & !hit).
- Inputs are stable while stalled, because EX/MEM holds on the stall.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Reset values: out_d_cache_stall=0, out_hit=0, out_misaligned=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out_load_data=0 (all with no access presented).
- Outside WRITEBACK/FILL: mem_we, mem_addr and mem_wdata drive 0.

Test Plan:
1. Cold load: after reset, LW 0x0000_0040 -> stall=1; FILL with mem_addr=0x40. Return mem_rdata word0=0xDEADBEEF -> stall drops one cycle after mem_ready; out_load_data=0xDEADBEEF, out_hit=1.
2. Store hit and extension: SB 0x80 to 0x41 on a resident line. Then LB 0x41 -> 0xFFFFFF80; LBU 0x41 -> 0x00000080; no mem_req raised.
3. Dirty eviction: store to 0x40, then LW 0x140 (same index, different tag) -> WRITEBACK with mem_addr=0x40, mem_we=1 and the stored byte in mem_wdata. Then FILL with mem_addr=0x140.
4. Handshake hold: delay mem_ready by 7 cycles -> mem_req, mem_addr and stall stay constant for all 7 cycles.
5. Misaligned: LW 0x42 -> out_misaligned=1, stall=0, no mem_req; SH 0x43 leaves the line unchanged.
6. Reset mid-FILL: assert reset during FILL -> mem_req falls immediately; a later mem_ready is ignored. Then LW 0x40 misses again, because all lines are invalid.

Source files
------------

// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Misses stall the pipeline while whole lines are evicted/filled over a req/ready handshake.
module dcache_mem_stage #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             in_addr,
  input  logic [31:0]             in_wdata,
  input  logic                    in_mem_read,
  input  logic                    in_mem_write,
  input  logic [2:0]              in_funct3,
  output logic [31:0]             out_load_data,
  output logic                    out_hit,
  output logic                    out_d_cache_stall,
  output logic                    out_misaligned,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  input  logic                    mem_ready
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state, state_nx;

  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  logic [OFF_W-1:0]      off;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [LINE_W-1:0]     cur_line, merged, wrep;
  logic [LINE_BYTES-1:0] be;
  logic access, hit, store_hit, fill_done;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;

  assign off       = in_addr[OFF_W-1:0];
  assign idx       = in_addr[OFF_W+IDX_W-1:OFF_W];
  assign tag       = in_addr[31:OFF_W+IDX_W];
  assign cur_line  = data_mem[idx];
  assign access    = (in_mem_read | in_mem_write) & ~out_misaligned;
  assign hit       = valid[idx] & (tag_mem[idx] == tag);
  assign store_hit = (state == IDLE) & access & hit & in_mem_write;
  assign fill_done = (state == FILL) & mem_ready;

  always_comb begin
    out_misaligned = 1'b0;
    if (in_mem_read | in_mem_write) begin
      case (in_funct3[1:0])
        2'b01:   out_misaligned = in_addr[0];
        2'b10:   out_misaligned = |in_addr[1:0];
        default: out_misaligned = 1'b0;
      endcase
    end
  end

  // Aligned accesses let the store data be replicated across the line and picked by byte enables.
  always_comb begin
    case (in_funct3[1:0])
      2'b00: begin
        be   = LINE_BYTES'(1) << off;
        wrep = {LINE_BYTES{in_wdata[7:0]}};
      end
      2'b01: begin
        be   = LINE_BYTES'(3) << off;
        wrep = {(LINE_BYTES/2){in_wdata[15:0]}};
      end
      default: begin
        be   = LINE_BYTES'(15) << off;
        wrep = {(LINE_BYTES/4){in_wdata}};
      end
    endcase
    merged = cur_line;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (be[b]) merged[b*8 +: 8] = wrep[b*8 +: 8];
    end
  end

  assign ld_byte = cur_line[{off, 3'b000} +: 8];
  assign ld_half = cur_line[{off[OFF_W-1:1], 4'b0000} +: 16];
  assign ld_word = cur_line[{off[OFF_W-1:2], 5'b00000} +: 32];

  // Data and tags carry no reset; only valid/dirty qualify them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= tag;
    end else if (store_hit) begin
      data_mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_done) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (access && !hit) state_nx = (valid[idx] && dirty[idx]) ? WRITEBACK : FILL;
      WRITEBACK: if (mem_ready) state_nx = FILL;
      FILL:      if (mem_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_hit           = 1'b0;
    out_d_cache_stall = 1'b0;
    out_load_data     = 32'h0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = 32'h0;
    mem_wdata         = '0;
    case (state)
      IDLE: begin
        out_hit           = access & hit;
        out_d_cache_stall = access & ~hit;
        if (access && hit && in_mem_read) begin
          case (in_funct3)
            3'b000:  out_load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  out_load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  out_load_data = {24'h0, ld_byte};
            3'b101:  out_load_data = {16'h0, ld_half};
            default: out_load_data = ld_word;
          endcase
        end
      end
      WRITEBACK: begin
        out_d_cache_stall = 1'b1;
        mem_req           = 1'b1;
        mem_we            = 1'b1;
        mem_addr          = {tag_mem[idx], idx, {OFF_W{1'b0}}};
        mem_wdata         = cur_line;
      end
      FILL: begin
        out_d_cache_stall = 1'b1;
        mem_req           = 1'b1;
        mem_addr          = {in_addr[31:OFF_W], {OFF_W{1'b0}}};
      end
      default: ;
    endcase
  end
endmodule
